// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    // Encoding 3 is reserved and handled the same as TRAP.
    typedef enum logic [1:0] {
        BR   = 2'd0,
        JMP  = 2'd1,
        TRAP = 2'd2
    } redirect_e;

    localparam int          PC_INC    = 4;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: redirect (trap > jump > branch) over +4 over hold,
// with alignment check on branch/jump targets.
module next_pc_sel import cpu_pkg::*; #(
    parameter int                PC_LEN   = 32,
    parameter logic [PC_LEN-1:0] TRAP_VEC = cpu_pkg::TRAP_VEC
) (
    input  logic [PC_LEN-1:0] pc_cur,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_type,
    input  logic [PC_LEN-1:0] redirect_target,
    input  logic              inc_en,
    output logic [PC_LEN-1:0] next_pc,
    output logic              misalign
);

    logic is_trap;

    assign is_trap = !((redirect_type == BR) || (redirect_type == JMP));

    // Select the PC for the next edge; a misaligned target is sent to the trap vector.
    always_comb begin
        next_pc  = pc_cur;
        misalign = 1'b0;
        if (redirect_valid) begin
            if (is_trap) begin
                next_pc = TRAP_VEC;
            end else if (redirect_target[1:0] != 2'b00) begin
                next_pc  = TRAP_VEC;
                misalign = 1'b1;
            end else begin
                next_pc = redirect_target;
            end
        end else if (inc_en) begin
            next_pc = pc_cur + PC_LEN'(PC_INC);
        end
    end

endmodule

// File: rtl/pc.sv
// Program counter register; loads pc_in every cycle.
module pc #(
    parameter int                PC_LEN    = 32,
    parameter logic [PC_LEN-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_LEN-1:0] pc_in,
    output logic [PC_LEN-1:0] pc_out
);

    // PC storage; the controller holds the value by feeding it back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_out <= RESET_VEC;
        else        pc_out <= pc_in;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem fetch at a time and
// discards responses made stale by a redirect.
module pc_fetch_ctrl import cpu_pkg::*; #(
    parameter int                PC_LEN    = 32,
    parameter logic [PC_LEN-1:0] RESET_VEC = cpu_pkg::RESET_VEC,
    parameter logic [PC_LEN-1:0] TRAP_VEC  = cpu_pkg::TRAP_VEC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_type,
    input  logic [PC_LEN-1:0] redirect_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_LEN-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    output logic              instr_valid,
    output logic [PC_LEN-1:0] instr_pc,
    output logic [PC_LEN-1:0] pc_out,
    output logic              misalign_err,
    output logic [1:0]        state_out
);

    fetch_state_e      state, state_nxt;
    logic              stale, stale_nxt;
    logic              halt_pend, halt_pend_nxt;
    logic              handshake;
    logic              rsp_good;
    logic [PC_LEN-1:0] next_pc;
    logic              misalign;

    assign imem_req_valid = (state == REQ) && !stall;
    assign handshake      = imem_req_valid && imem_req_ready;
    // A same-cycle redirect also drops the response.
    assign rsp_good       = (state == WAIT) && imem_rsp_valid && !stale && !redirect_valid;
    assign imem_req_addr  = pc_out;
    assign state_out      = state;

    next_pc_sel #(
        .PC_LEN   (PC_LEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_pc_sel (
        .pc_cur          (pc_out),
        .redirect_valid  (redirect_valid),
        .redirect_type   (redirect_type),
        .redirect_target (redirect_target),
        .inc_en          (rsp_good),
        .next_pc         (next_pc),
        .misalign        (misalign)
    );

    pc #(
        .PC_LEN    (PC_LEN),
        .RESET_VEC (RESET_VEC)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .pc_in  (next_pc),
        .pc_out (pc_out)
    );

    // FSM state, stale-response flag and pending halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stale     <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            stale     <= stale_nxt;
            halt_pend <= halt_pend_nxt;
        end
    end

    // Next-state logic; a handshake beats halt, halt beats resume.
    always_comb begin
        state_nxt     = state;
        stale_nxt     = stale;
        halt_pend_nxt = halt_pend;
        case (state)
            IDLE: state_nxt = halt_req ? HALTED : REQ;
            REQ: begin
                if (handshake) begin
                    state_nxt = WAIT;
                    stale_nxt = redirect_valid;
                end else if (halt_req) begin
                    state_nxt = HALTED;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    stale_nxt = 1'b0;
                    state_nxt = (halt_req || halt_pend) ? HALTED : REQ;
                end else begin
                    if (redirect_valid) stale_nxt = 1'b1;
                    if (halt_req)       halt_pend_nxt = 1'b1;
                end
            end
            HALTED: if (resume && !halt_req) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == HALTED) halt_pend_nxt = 1'b0;
    end

    // Registered completion and misalign pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid  <= 1'b0;
            instr_pc     <= '0;
            misalign_err <= 1'b0;
        end else begin
            instr_valid  <= rsp_good;
            misalign_err <= misalign;
            if (rsp_good) instr_pc <= pc_out;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; inputs change and outputs are sampled 1 ns after posedge.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_type;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc_out;
    logic        misalign_err;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_type   (redirect_type),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .resume          (resume),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .instr_valid     (instr_valid),
        .instr_pc        (instr_pc),
        .pc_out          (pc_out),
        .misalign_err    (misalign_err),
        .state_out       (state_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch from REQ with ready=1 and the response one cycle after the handshake.
    task automatic fetch_one(input logic [31:0] addr);
        check("req_state", 32'(state_out), 32'd1);
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_req_addr, addr);
        tick();
        check("wait_state", 32'(state_out), 32'd2);
        check("wait_no_req", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        check("instr_valid", 32'(instr_valid), 32'd1);
        check("instr_pc", instr_pc, addr);
    endtask

    task automatic redirect(input logic [1:0] rtype, input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_type   = rtype;
        redirect_target = target;
        tick();
        redirect_valid  = 1'b0;
        redirect_type   = 2'd0;
        redirect_target = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_type = 2'd0;
        redirect_target = 32'h0; halt_req = 1'b0; resume = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
        #12;
        check("rst_pc", pc_out, 32'h0);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        rst_n = 1'b1;

        // Boot bubble then three sequential fetches.
        tick();
        check("boot_state", 32'(state_out), 32'd1);
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_one(32'h8);
        check("seq_pc", pc_out, 32'hC);

        // Jump while the fetch is in flight: response dropped.
        tick();
        redirect(2'd1, 32'h40);
        check("jmp_state", 32'(state_out), 32'd2);
        check("jmp_pc", pc_out, 32'h40);
        imem_rsp_valid = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        check("stale_drop", 32'(instr_valid), 32'd0);
        check("stale_state", 32'(state_out), 32'd1);
        check("stale_pc", pc_out, 32'h40);
        fetch_one(32'h40);

        // Misaligned branch goes to the trap vector with a one-cycle error pulse.
        imem_req_ready = 1'b0;
        redirect(2'd0, 32'h22);
        check("mis_pulse", 32'(misalign_err), 32'd1);
        check("mis_pc", imem_req_addr, 32'h100);
        tick();
        check("mis_pulse_end", 32'(misalign_err), 32'd0);
        check("mis_state", 32'(state_out), 32'd1);
        imem_req_ready = 1'b1;
        fetch_one(32'h100);

        // Trap and reserved type both ignore the target.
        imem_req_ready = 1'b0;
        redirect(2'd2, 32'h44);
        check("trap_pc", pc_out, 32'h100);
        check("trap_no_mis", 32'(misalign_err), 32'd0);
        imem_req_ready = 1'b1;
        fetch_one(32'h100);
        imem_req_ready = 1'b0;
        redirect(2'd3, 32'h48);
        check("rsvd_pc", pc_out, 32'h100);
        imem_req_ready = 1'b1;
        fetch_one(32'h100);

        // Stall holds off the request.
        stall = 1'b1;
        #1;
        check("stall_valid", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid_hold", 32'(imem_req_valid), 32'd0);
            check("stall_pc", pc_out, 32'h104);
            check("stall_state", 32'(state_out), 32'd1);
        end
        stall = 1'b0;
        #1;
        check("unstall_valid", 32'(imem_req_valid), 32'd1);
        fetch_one(32'h104);

        // Halt latched in WAIT, then halt+resume together, then resume.
        check("halt_addr", imem_req_addr, 32'h108);
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_wait", 32'(state_out), 32'd2);
        imem_rsp_valid = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        check("halt_instr_valid", 32'(instr_valid), 32'd1);
        check("halt_instr_pc", instr_pc, 32'h108);
        check("halt_state", 32'(state_out), 32'd3);
        check("halt_no_req", 32'(imem_req_valid), 32'd0);
        halt_req = 1'b1;
        resume = 1'b1;
        tick();
        halt_req = 1'b0;
        resume = 1'b0;
        check("halt_resume_both", 32'(state_out), 32'd3);
        tick();
        check("halted_idle", 32'(imem_req_valid), 32'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_state", 32'(state_out), 32'd1);
        check("resume_addr", imem_req_addr, 32'h10C);

        // PC wraps at the top of the address space.
        imem_req_ready = 1'b0;
        redirect(2'd1, 32'hFFFF_FFFC);
        check("top_pc", pc_out, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        fetch_one(32'hFFFF_FFFC);
        check("wrap_pc", pc_out, 32'h0);
        fetch_one(32'h0);
        fetch_one(32'h4);

        // Asynchronous reset in the middle of WAIT.
        tick();
        check("pre_rst_state", 32'(state_out), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc_out, 32'h0);
        check("arst_state", 32'(state_out), 32'd0);
        check("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("arst_instr_valid", 32'(instr_valid), 32'd0);
        check("arst_instr_pc", instr_pc, 32'h0);
        check("arst_misalign", 32'(misalign_err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rerun_state", 32'(state_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
